// File: rtl/boot_pkg.sv
// Shared types and defaults for the serial boot loader.
package boot_pkg;

    localparam int unsigned DEPTH_WORDS_DEFAULT = 32'd8192;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } boot_state_t;

    // Running frame checksum: byte-wise XOR of the payload.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte receive strobe and instruction-memory write bus of the boot loader.
interface boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic        debug;
    logic        cpu_hold;
    logic        boot_done;
    logic        boot_err;

    modport master (
        output rx_valid, rx_data,
        input  boot_addr, boot_data, debug, cpu_hold, boot_done, boot_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output boot_addr, boot_data, debug, cpu_hold, boot_done, boot_err
    );
endinterface

// File: rtl/boot_loader_byte_packer.sv
// Little-endian 4-byte to 32-bit word assembler; word_done marks the fourth byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0]  idx_r;
    logic [23:0] lo_r;

    // Hold the first three bytes; the fourth is merged combinationally so the caller can register the word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_r <= 2'd0;
            lo_r  <= 24'd0;
        end else if (in_valid) begin
            idx_r <= idx_r + 2'd1;
            case (idx_r)
                2'd0:    lo_r[7:0]   <= in_byte;
                2'd1:    lo_r[15:8]  <= in_byte;
                2'd2:    lo_r[23:16] <= in_byte;
                default: lo_r        <= lo_r;
            endcase
        end else begin
            idx_r <= idx_r;
            lo_r  <= lo_r;
        end
    end

    assign word      = {in_byte, lo_r};
    assign word_done = in_valid && (idx_r == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: parses SYNC/LEN/data/CHK frames and writes words into instruction memory.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS) + 1;

    boot_state_t  state_r;
    logic [7:0]   len_lo_r;
    logic [15:0]  len_r;
    logic [7:0]   xor_r;
    logic [AW-1:0] addr_r;
    logic [31:0]  boot_addr_r;
    logic [31:0]  boot_data_r;
    logic         debug_r;
    logic         cpu_hold_r;
    logic         boot_done_r;
    logic         boot_err_r;

    logic         sync_s;
    logic [15:0]  len_s;
    logic [AW-1:0] addr_next_s;
    logic         pack_clr_s;
    logic         pack_valid_s;
    logic [31:0]  word_s;
    logic         word_done_s;

    assign sync_s       = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign len_s        = {bus.rx_data, len_lo_r};
    assign addr_next_s  = addr_r + AW'(1);
    assign pack_clr_s   = (state_r != ST_DATA);
    assign pack_valid_s = bus.rx_valid && (state_r == ST_DATA);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr_s),
        .in_valid  (pack_valid_s),
        .in_byte   (bus.rx_data),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Frame parser FSM with registered write strobe and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_lo_r    <= 8'd0;
            len_r       <= 16'd0;
            xor_r       <= 8'd0;
            addr_r      <= '0;
            boot_addr_r <= 32'd0;
            boot_data_r <= 32'd0;
            debug_r     <= 1'b0;
            cpu_hold_r  <= 1'b1;
            boot_done_r <= 1'b0;
            boot_err_r  <= 1'b0;
        end else begin
            debug_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sync_s) begin
                        state_r <= ST_LEN_LO;
                        xor_r   <= 8'd0;
                        addr_r  <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (bus.rx_valid) begin
                        len_lo_r <= bus.rx_data;
                        state_r  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (bus.rx_valid) begin
                        len_r <= len_s;
                        if (32'(len_s) > DEPTH_WORDS) begin
                            state_r    <= ST_ERR;
                            boot_err_r <= 1'b1;
                        end else if (len_s == 16'd0) begin
                            state_r <= ST_CHK;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.rx_valid) begin
                        xor_r <= xor_fold(xor_r, bus.rx_data);
                        if (word_done_s) begin
                            boot_addr_r <= 32'(addr_r);
                            boot_data_r <= word_s;
                            debug_r     <= 1'b1;
                            addr_r      <= addr_next_s;
                            if (32'(addr_next_s) == 32'(len_r)) begin
                                state_r <= ST_CHK;
                            end
                        end
                    end
                end
                ST_CHK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == xor_r) begin
                            state_r     <= ST_DONE;
                            boot_done_r <= 1'b1;
                            cpu_hold_r  <= 1'b0;
                        end else begin
                            state_r    <= ST_ERR;
                            boot_err_r <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    // A new SYNC restarts the loader; anything else leaves the verdict in place.
                    if (sync_s) begin
                        state_r     <= ST_LEN_LO;
                        xor_r       <= 8'd0;
                        addr_r      <= '0;
                        boot_done_r <= 1'b0;
                        boot_err_r  <= 1'b0;
                        cpu_hold_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cpu_hold_r  <= 1'b1;
                    boot_done_r <= 1'b0;
                    boot_err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.boot_addr = boot_addr_r;
    assign bus.boot_data = boot_data_r;
    assign bus.debug     = debug_r;
    assign bus.cpu_hold  = cpu_hold_r;
    assign bus.boot_done = boot_done_r;
    assign bus.boot_err  = boot_err_r;

endmodule
